// File: rtl/date_counter.sv
// date_counter: day/month/year calendar counter.
// Advances one day per cin strobe, up (dir=0) or down (dir=1), with
// per-month lengths, Gregorian leap years and wrap across
// YEAR_MIN..YEAR_MAX. A synchronous preset load is checked against the
// calendar; an invalid preset leaves the state untouched and pulses
// load_err for one cycle.
// Ports:
//   clk                   rising-edge clock
//   rst                   synchronous reset, active low (-> 1/1/YEAR_MIN)
//   cin, dir              advance-one-day strobe and its direction
//   load, load_day/month/year  preset request and value
//   day, month, year      current date
//   leap                  current year is a leap year (combinational)
//   cout                  wrap carry, valid in the same cycle as cin
//   load_err              one-cycle pulse after a rejected load
module date_counter #(
  parameter int YEAR_W   = 12,
  parameter int YEAR_MIN = 2000,
  parameter int YEAR_MAX = 2099
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cin,
  input  logic              dir,
  input  logic              load,
  input  logic [4:0]        load_day,
  input  logic [3:0]        load_month,
  input  logic [YEAR_W-1:0] load_year,
  output logic [4:0]        day,
  output logic [3:0]        month,
  output logic [YEAR_W-1:0] year,
  output logic              leap,
  output logic              cout,
  output logic              load_err
);

  localparam logic [YEAR_W-1:0] YMIN = YEAR_W'(YEAR_MIN);
  localparam logic [YEAR_W-1:0] YMAX = YEAR_W'(YEAR_MAX);

  function automatic logic is_leap(input logic [YEAR_W-1:0] y);
    return (y[1:0] == 2'b00) &&
           (((y % YEAR_W'(100)) != '0) || ((y % YEAR_W'(400)) == '0));
  endfunction

  function automatic logic [4:0] dim(input logic [3:0] m, input logic lp);
    case (m)
      4'd4, 4'd6, 4'd9, 4'd11: return 5'd30;
      4'd2:                    return lp ? 5'd29 : 5'd28;
      default:                 return 5'd31;
    endcase
  endfunction

  logic [4:0]        day_q,   day_d;
  logic [3:0]        month_q, month_d;
  logic [YEAR_W-1:0] year_q,  year_d;
  logic              err_q,   err_d;

  logic       leap_cur;
  logic [4:0] dim_cur;
  logic       load_ok;
  logic       at_top, at_bot;

  assign leap_cur = is_leap(year_q);
  assign dim_cur  = dim(month_q, leap_cur);

  // Preset is validated against its own year's leap status, not the current one.
  assign load_ok = (load_month >= 4'd1) && (load_month <= 4'd12) &&
                   (load_year >= YMIN) && (load_year <= YMAX) &&
                   (load_day >= 5'd1) &&
                   (load_day <= dim(load_month, is_leap(load_year)));

  assign at_top = (day_q == 5'd31) && (month_q == 4'd12) && (year_q == YMAX);
  assign at_bot = (day_q == 5'd1)  && (month_q == 4'd1)  && (year_q == YMIN);

  // load suppresses the strobe, so cout must too.
  assign cout = cin && !load && rst && (dir ? at_bot : at_top);

  always_comb begin
    day_d   = day_q;
    month_d = month_q;
    year_d  = year_q;
    err_d   = 1'b0;
    if (load) begin
      if (load_ok) begin
        day_d   = load_day;
        month_d = load_month;
        year_d  = load_year;
      end else begin
        err_d = 1'b1;
      end
    end else if (cin) begin
      if (!dir) begin
        if (day_q < dim_cur) begin
          day_d = day_q + 5'd1;
        end else if (month_q < 4'd12) begin
          day_d   = 5'd1;
          month_d = month_q + 4'd1;
        end else begin
          day_d   = 5'd1;
          month_d = 4'd1;
          year_d  = (year_q < YMAX) ? year_q + YEAR_W'(1) : YMIN;
        end
      end else begin
        if (day_q > 5'd1) begin
          day_d = day_q - 5'd1;
        end else if (month_q > 4'd1) begin
          // Previous month lies in the same year, so the current leap flag applies.
          month_d = month_q - 4'd1;
          day_d   = dim(month_q - 4'd1, leap_cur);
        end else begin
          day_d   = 5'd31;
          month_d = 4'd12;
          year_d  = (year_q > YMIN) ? year_q - YEAR_W'(1) : YMAX;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      day_q   <= 5'd1;
      month_q <= 4'd1;
      year_q  <= YMIN;
      err_q   <= 1'b0;
    end else begin
      day_q   <= day_d;
      month_q <= month_d;
      year_q  <= year_d;
      err_q   <= err_d;
    end
  end

  assign day      = day_q;
  assign month    = month_q;
  assign year     = year_q;
  assign leap     = leap_cur;
  assign load_err = err_q;

endmodule

// File: doc/date_counter.md
Name: date_counter

Overview:
Parametrised calendar counter that succeeds the standalone month counter. It holds day, month and year and advances them by one day per qualified carry-in from the hour stage. It handles per-month day lengths, Gregorian leap years, bidirectional counting, synchronous preset load and configurable year-range wrap. It sits in the clock/calendar datapath between the hour counter (cin source) and the display/decoder logic.

Parameters:
YEAR_W, 12, width of year register/port
YEAR_MIN, 2000, first year of range; reset and wrap-up target
YEAR_MAX, 2099, last year of range; wrap-down target (YEAR_MIN < YEAR_MAX < 2**YEAR_W required)

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous reset, active-low
cin  in  1  advance-one-day strobe (one cycle per day)
dir  in  1  0 = count up, 1 = count down; sampled with cin
load  in  1  synchronous preset request
load_day  in  5  preset day, 1..31
load_month  in  4  preset month, 1..12
load_year  in  YEAR_W  preset year
day  out  5  current day, 1..days_in_month
month  out  4  current month, 1..12
year  out  YEAR_W  current year, YEAR_MIN..YEAR_MAX
leap  out  1  combinational: current year is a leap year
cout  out  1  combinational range-wrap carry
load_err  out  1  registered; 1-cycle pulse when a load is rejected

Behaviour:
- Interface: one clock; reset is synchronous and active-low. Clock port is clk; reset port is rst (low = reset).
- Reset, on a clk edge with rst=0: day=1, month=1, year=YEAR_MIN, load_err=0. Reset overrides load and cin.
- Priority: reset > load > cin. A cin arriving in the same cycle as a load is dropped.
- leap = (year%4==0) && ((year%100!=0) || (year%400==0)).
- days_in_month: months 4, 6, 9 and 11 have 30 days. Month 2 has 28 days, or 29 if leap. All other months have 31.
- Load: accepted when load_month is 1..12, load_year is YEAR_MIN..YEAR_MAX, and load_day is 1..days_in_month(load_month, leap(load_year)).
  - Accepted: state takes the preset on the next edge; load_err=0.
  - Rejected: state is unchanged; load_err=1 for exactly one cycle.
- Up count (cin=1, dir=0), applied on the next edge:
  - day < dim: day+1.
  - day == dim and month < 12: day=1, month+1.
  - day=31, month=12, year < YEAR_MAX: day=1, month=1, year+1.
  - 31/12/YEAR_MAX: 1/1/YEAR_MIN.
- Down count (cin=1, dir=1), applied on the next edge:
  - day > 1: day-1.
  - day=1 and month > 1: month-1, day = dim(month-1, current year).
  - 1/1, year > YEAR_MIN: 31/12/year-1.
  - 1/1/YEAR_MIN: 31/12/YEAR_MAX.
- cout = cin && !load && rst && at the wrap boundary. The boundary is 31/12/YEAR_MAX for dir=0 and 1/1/YEAR_MIN for dir=1. cout is combinational, so it is valid in the same cycle as the cin that causes the wrap.
- cin=0 and no load: state holds, cout=0.
- No latency beyond one edge. Any state change is visible the cycle after the qualifying input.
- The state is always a valid date. There is no clamping path because invalid loads are rejected.
- Reset asserted mid-sequence (including during a load or cin cycle) returns the state to 1/1/YEAR_MIN on that edge. No pending operation survives the reset.

Test Plan:
- Reset: rst=0 for 2 cycles with cin=1, load=1 -> day=1, month=1, year=2000, cout=0, load_err=0.
- Leap February: load 28/2/2024, pulse cin twice (dir=0) -> 29/2/2024, then 1/3/2024. Load 28/2/2100 with YEAR_MAX=2199 -> next cin gives 1/3/2100, and leap=0.
- Year wrap up: load 31/12/2099, cin=1, dir=0 -> cout=1 in that cycle, next state 1/1/2000. Down from 1/1/2000 -> cout=1, next state 31/12/2099.
- Down across a month: load 1/3/2000, cin with dir=1 -> 29/2/2000. Load 1/5/2001 -> 30/4/2001.
- Invalid loads: 30/2/2024, 31/4/2001, 1/13/2001 and 1/1/1999 -> each is rejected, state unchanged, load_err high for exactly 1 cycle.
- Simultaneous events: load 15/6/2050 with cin=1 in the same cycle -> state 15/6/2050, cin dropped, cout=0. Full up-sweep of 366 cin pulses from 1/1/2000 -> 1/1/2001 with no cout.
